// File: rtl/air_con_ctrl_if.sv
// rtl/air_con_ctrl_if.sv - sensor/mode inputs and drive/status outputs of air_con_ctrl
interface air_con_ctrl_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] temperature;
    logic             temp_valid;
    logic [1:0]       mode;
    logic             heating;
    logic             cooling;
    logic [1:0]       state;
    logic             dwell_busy;

    modport master (
        output temperature, temp_valid, mode,
        input  heating, cooling, state, dwell_busy
    );

    modport slave (
        input  temperature, temp_valid, mode,
        output heating, cooling, state, dwell_busy
    );
endinterface

// File: rtl/air_con_ctrl.sv
// rtl/air_con_ctrl.sv - IDLE/HEAT/COOL thermostat with hysteresis and mode gating; AC_DWELL_EN adds the minimum-dwell lockout
module air_con_ctrl #(
    parameter int WIDTH     = 5,
    parameter int HEAT_ON   = 18,
    parameter int HEAT_OFF  = 20,
    parameter int COOL_OFF  = 20,
    parameter int COOL_ON   = 22,
    parameter int MIN_DWELL = 4
) (
    input  logic          clk,
    input  logic          rst,
    air_con_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HEAT = 2'b01,
        COOL = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] T_HEAT_ON  = WIDTH'(HEAT_ON);
    localparam logic [WIDTH-1:0] T_HEAT_OFF = WIDTH'(HEAT_OFF);
    localparam logic [WIDTH-1:0] T_COOL_OFF = WIDTH'(COOL_OFF);
    localparam logic [WIDTH-1:0] T_COOL_ON  = WIDTH'(COOL_ON);

    state_t state_q;
    state_t state_d;
    logic   lockout;
    logic   heat_ok;
    logic   cool_ok;

    // mode bit 0 permits heating, bit 1 permits cooling (AUTO = both)
    assign heat_ok   = bus.mode[0];
    assign cool_ok   = bus.mode[1];
    assign bus.state = state_q;

    always_comb begin
        state_d = state_q;
        if (state_q == HEAT && !heat_ok) begin
            state_d = IDLE;
        end else if (state_q == COOL && !cool_ok) begin
            state_d = IDLE;
        end else if (bus.temp_valid && !lockout) begin
            case (state_q)
                IDLE: begin
                    if (heat_ok && bus.temperature <= T_HEAT_ON)
                        state_d = HEAT;
                    else if (cool_ok && bus.temperature >= T_COOL_ON)
                        state_d = COOL;
                end
                HEAT: if (bus.temperature >= T_HEAT_OFF) state_d = IDLE;
                COOL: if (bus.temperature <= T_COOL_OFF) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus.heating <= 1'b0;
            bus.cooling <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus.heating <= (state_d == HEAT);
            bus.cooling <= (state_d == COOL);
        end
    end

`ifdef AC_DWELL_EN
    localparam int            DW         = $clog2(MIN_DWELL + 1);
    localparam logic [DW-1:0] DWELL_LOAD = DW'(MIN_DWELL - 1);

    logic [DW-1:0] dwell_cnt;
    logic [DW-1:0] dwell_d;

    assign lockout = (dwell_cnt != '0);

    // every state change reloads, forced exits included
    always_comb begin
        dwell_d = dwell_cnt;
        if (state_d != state_q)
            dwell_d = DWELL_LOAD;
        else if (dwell_cnt != '0)
            dwell_d = dwell_cnt - DW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_cnt      <= '0;
            bus.dwell_busy <= 1'b0;
        end else begin
            dwell_cnt      <= dwell_d;
            bus.dwell_busy <= (dwell_d != '0);
        end
    end
`else
    // no counter in this build; MIN_DWELL has no effect
    assign lockout        = (MIN_DWELL < 0);
    assign bus.dwell_busy = 1'b0;
`endif
endmodule

// File: tb/tb_air_con_ctrl.sv
// tb/tb_air_con_ctrl.sv - directed self-checking bench for air_con_ctrl (expectations follow AC_DWELL_EN)
module tb_air_con_ctrl;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_HEAT = 2'b01;
    localparam logic [1:0] S_COOL = 2'b10;
`ifdef AC_DWELL_EN
    localparam logic DW = 1'b1;
`else
    localparam logic DW = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // hysteresis sweep: each temperature held 8 edges, long enough for two dwell periods
    logic [4:0] sw_t [0:12] = '{5'd24, 5'd17, 5'd19, 5'd20, 5'd23, 5'd21, 5'd20,
                                5'd22, 5'd21, 5'd20, 5'd19, 5'd18, 5'd20};
    logic [1:0] sw_s [0:12] = '{S_COOL, S_HEAT, S_HEAT, S_IDLE, S_COOL, S_COOL, S_IDLE,
                                S_COOL, S_COOL, S_IDLE, S_IDLE, S_HEAT, S_IDLE};
    // COOL with temperature dropped to 10, edges 2..9 after entry
    logic [1:0] rev_dw [0:7] = '{S_COOL, S_COOL, S_COOL, S_IDLE, S_IDLE, S_IDLE, S_IDLE, S_HEAT};
    logic [1:0] rev_nd [0:7] = '{S_IDLE, S_HEAT, S_HEAT, S_HEAT, S_HEAT, S_HEAT, S_HEAT, S_HEAT};
    logic       rev_bz [0:7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    air_con_ctrl_if #(.WIDTH(5)) bus ();

    air_con_ctrl #(
        .WIDTH(5), .HEAT_ON(18), .HEAT_OFF(20), .COOL_OFF(20), .COOL_ON(22), .MIN_DWELL(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [1:0] st, input logic busy);
        check({tag, ".state"}, {6'd0, bus.state}, {6'd0, st});
        check({tag, ".heating"}, {7'd0, bus.heating}, {7'd0, st == S_HEAT});
        check({tag, ".cooling"}, {7'd0, bus.cooling}, {7'd0, st == S_COOL});
        check({tag, ".dwell_busy"}, {7'd0, bus.dwell_busy}, {7'd0, busy});
    endtask

    task automatic drive(input logic [4:0] t, input logic v, input logic [1:0] m);
        bus.temperature = t;
        bus.temp_valid  = v;
        bus.mode        = m;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        drive(5'd10, 1'b1, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        expect_out("reset", S_IDLE, 1'b0);
        rst = 1'b0;
        tick(1);
        expect_out("first_edge", S_HEAT, DW);

        #2 rst = 1'b1;
        #1 expect_out("async_reset", S_IDLE, 1'b0);
        drive(5'd21, 1'b1, 2'b11);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            drive(sw_t[i], 1'b1, 2'b11);
            tick(8);
            expect_out($sformatf("sweep%0d_t%0d", i, sw_t[i]), sw_s[i], 1'b0);
        end

        drive(5'd17, 1'b1, 2'b11);
        tick(1);
        expect_out("dwell_e1", S_HEAT, DW);
        drive(5'd20, 1'b1, 2'b11);
        tick(1);
        expect_out("dwell_e2", DW ? S_HEAT : S_IDLE, DW);
        tick(1);
        expect_out("dwell_e3", DW ? S_HEAT : S_IDLE, DW);
        tick(1);
        expect_out("dwell_e4", DW ? S_HEAT : S_IDLE, 1'b0);
        tick(1);
        expect_out("dwell_e5", S_IDLE, DW);
        tick(3);
        expect_out("dwell_clear", S_IDLE, 1'b0);

        drive(5'd23, 1'b1, 2'b11);
        tick(1);
        expect_out("rev_cool", S_COOL, DW);
        drive(5'd10, 1'b1, 2'b11);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            expect_out($sformatf("rev_e%0d", i + 2), DW ? rev_dw[i] : rev_nd[i], rev_bz[i] & DW);
        end

        drive(5'd10, 1'b1, 2'b11);
        tick(4);
        drive(5'd20, 1'b1, 2'b11);
        tick(1);
        expect_out("heat_exit", S_IDLE, DW);
        tick(3);
        drive(5'd23, 1'b1, 2'b11);
        tick(1);
        expect_out("cool_entry", S_COOL, DW);
        drive(5'd23, 1'b1, 2'b01);
        tick(1);
        expect_out("force_heat_only", S_IDLE, DW);
        tick(7);
        expect_out("heat_only_no_cool", S_IDLE, 1'b0);
        drive(5'd10, 1'b1, 2'b01);
        tick(1);
        expect_out("heat_only_heat", S_HEAT, DW);
        drive(5'd10, 1'b0, 2'b00);
        tick(1);
        expect_out("force_off_invalid", S_IDLE, DW);
        drive(5'd5, 1'b1, 2'b00);
        tick(8);
        expect_out("off_cold", S_IDLE, 1'b0);
        drive(5'd5, 1'b1, 2'b10);
        tick(4);
        expect_out("cool_only_cold", S_IDLE, 1'b0);

        drive(5'd30, 1'b0, 2'b11);
        tick(8);
        expect_out("invalid_hot", S_IDLE, 1'b0);
        drive(5'd30, 1'b1, 2'b11);
        tick(1);
        expect_out("valid_hot", S_COOL, DW);
        drive(5'd10, 1'b0, 2'b11);
        tick(8);
        expect_out("invalid_hold_cool", S_COOL, 1'b0);
        drive(5'd10, 1'b1, 2'b11);
        tick(1);
        expect_out("valid_cold_exit", S_IDLE, DW);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
